trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap sequencer for the pipelined RV32I core. It sits beside the EX stage and watches the decoded exception flags (illegal instruction, ecall, mret) and the external/timer interrupt lines. On a trap it freezes and flushes the front end, and writes mepc, mcause and mstatus through the single CSR write port. It then redirects the PC. That write port is shared with CSR instructions retiring from WB, and this block arbitrates between the two.

## Interface
Parameters:
- XLEN, 32, data/PC width
- RESET_IDLE, 1'b1, reserved; state register resets to IDLE

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a real instruction (not a bubble)
- ex_pc  in  32  PC of the EX instruction
- ex_illegal  in  1  pipelined invalid_instruction
- ex_ecall  in  1  EX instruction is ecall
- ex_mret  in  1  EX instruction is mret
- irq_ext  in  1  level external interrupt (compiled with TRAP_IRQ_EN)
- irq_timer  in  1  level timer interrupt (compiled with TRAP_IRQ_EN)
- csr_mstatus  in  32  current mstatus (combinational CSR read)
- csr_mie  in  32  current mie
- csr_mtvec  in  32  current mtvec
- csr_mepc  in  32  current mepc
- pipe_csr_we  in  1  WB-stage CSR instruction write request
- pipe_csr_addr  in  12  its address
- pipe_csr_wdata  in  32  its data
- csr_we  out  1  arbitrated CSR write enable
- csr_waddr  out  12  arbitrated CSR address
- csr_wdata  out  32  arbitrated CSR data
- stall  out  1  freeze PC, IF/ID and ID/EX
- flush  out  1  kill IF, ID and EX contents
- redirect_en  out  1  load PC from redirect_pc
- redirect_pc  out  32  trap vector or return address
- busy  out  1  sequence in progress (state != IDLE)

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, JUMP (trap path); M_STATUS, JUMP (mret path).
- IDLE detection applies only when ex_valid=1. Priority, highest first:
  - ext interrupt: irq_ext & mstatus[3] & mie[11]
  - timer interrupt: irq_timer & mstatus[3] & mie[7]
  - illegal instruction
  - ecall
  - mret
- Detection actions:
  - Assert flush and stall combinationally in the detection cycle.
  - Latch epc=ex_pc and cause.
  - Go to W_MEPC for a trap, or M_STATUS for mret.
- Cause codes: ext 32'h8000000B, timer 32'h80000007, illegal 32'h2, ecall 32'hB. mepc is ex_pc for every cause. The interrupted or faulting EX instruction is killed and is not retired.
- W_MEPC writes 12'h341 with epc.
- W_MCAUSE writes 12'h342 with cause.
- W_MSTATUS writes 12'h300 with the current mstatus modified as follows: bit7 (MPIE) gets the old bit3, bit3 (MIE) becomes 0, bits12:11 (MPP) become 2'b11.
- M_STATUS writes 12'h300 with the current mstatus modified as follows: bit3 gets the old bit7, bit7 becomes 1.
- JUMP: redirect_en=1 and flush=1; stall=0; no CSR write; next state IDLE.
  - Trap path: redirect_pc={mtvec[31:2],2'b00} (direct mode only).
  - mret path: redirect_pc is csr_mepc, sampled in JUMP.
- CSR port arbitration:
  - pipe_csr_we=1 always wins and passes through unchanged.
  - A write state that collides with it holds its state for that cycle, and stall stays high.
  - In IDLE and JUMP the port carries the pipeline write only.
- While busy, all ex_* and irq inputs are ignored. Level interrupts still pending after JUMP are re-evaluated from the next IDLE cycle, subject to the updated MIE.

## Timing
- Reset values: csr_we=0, csr_waddr=0, csr_wdata=0, stall=0, flush=0, redirect_en=0, redirect_pc=0, busy=0, state=IDLE.
- Trap with no collisions:
  - Detect at cycle T.
  - CSR writes at T+1, T+2 and T+3.
  - Redirect at T+4.
  - First vector fetch at T+5.
  - Each pipeline CSR collision adds one cycle.
- mret: detect T, mstatus write T+1, redirect T+2.
- stall is high from T through the last write state and low in JUMP.
- rst during a sequence: state returns to IDLE on the next edge and all outputs reset. Any CSR write not yet issued is never issued.
- Simultaneous irq and ex_illegal in the same cycle: the interrupt is taken. mcause is the interrupt code and mepc=ex_pc, so the illegal instruction re-traps after mret.

## Configuration
- TRAP_IRQ_EN defined: irq_ext and irq_timer ports exist and interrupt detection is active.
- TRAP_IRQ_EN undefined:
  - The irq ports are removed.
  - Only illegal, ecall and mret are sequenced.
  - Interrupt cause codes are never produced.

## Structure
- defines.v gains:
  - CSR addresses (CSR_MSTATUS 12'h300, CSR_MEPC 12'h341, CSR_MCAUSE 12'h342)
  - cause codes
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11)
  - state encodings
- Sub-module trap_cause_encoder: a combinational priority encoder that takes the ex flags, irq lines and masks. It outputs take_trap, take_mret and cause[31:0].
- The FSM, epc/cause registers and port mux live in trap_ctrl.

## Test plan
- ex_illegal=1, ex_pc=0x100, mtvec=0x205, mstatus=0x8:
  - T+1 writes mepc=0x100.
  - T+2 writes mcause=0x2.
  - T+3 writes mstatus=0x1880.
  - T+4 gives redirect_pc=0x204.
- mret at ex_pc=0x210, mstatus=0x1880, mepc=0x104: T+1 writes mstatus=0x1888; T+2 gives redirect_pc=0x104.
- irq_timer=1, mie=0x80, mstatus=0x8, concurrent ex_ecall: mcause=0x80000007 and mepc=ex_pc. Repeat with mstatus=0: ecall is taken with mcause=0xB.
- pipe_csr_we=1 to 0x305 during W_MCAUSE: the pipeline write appears first, the mcause write follows one cycle later, and the redirect is at T+5.
- rst=1 at T+2 of a trap: at T+3 all outputs are 0, there is no mstatus write, and busy=0.
- With TRAP_IRQ_EN undefined: an illegal instruction still sequences exactly as in scenario 1.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared constants, state encoding and mstatus update helpers for the trap sequencer.
// Build option TRAP_IRQ_EN (see trap_ctrl.sv) does not change anything in this package.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_EXT_IRQ   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ILLEGAL   = 32'h0000_0002;
  localparam logic [31:0] CAUSE_ECALL     = 32'h0000_000B;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIE_MEIE       = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W_MEPC    = 3'd1,
    ST_W_MCAUSE  = 3'd2,
    ST_W_MSTATUS = 3'd3,
    ST_M_STATUS  = 3'd4,
    ST_JUMP      = 3'd5
  } trap_state_t;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] f;
    f = m;
    f[MSTATUS_MPIE] = m[MSTATUS_MIE];
    f[MSTATUS_MIE]  = 1'b0;
    f[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return f;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] f;
    f = m;
    f[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    f[MSTATUS_MPIE] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/trap_ctrl_cause_encoder.sv
// Priority encoder: ext irq > timer irq > illegal > ecall > mret; irq inputs exist only with TRAP_IRQ_EN.
// Latency: combinational. Backpressure: none, the caller decides when the result is acted on.
// Interrupt terms are already qualified by mstatus.MIE and the per-source mie enables.
module trap_cause_encoder
  import trap_ctrl_pkg::*;
(
  input  logic        ex_valid,
  input  logic        ex_illegal,
  input  logic        ex_ecall,
  input  logic        ex_mret,
`ifdef TRAP_IRQ_EN
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        mie_mtie,
`endif
  output logic        take_trap,
  output logic        take_mret,
  output logic [31:0] cause
);

  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    cause     = 32'h0;
    if (ex_valid) begin
`ifdef TRAP_IRQ_EN
      if (irq_ext && mstatus_mie && mie_meie) begin
        take_trap = 1'b1;
        cause     = CAUSE_EXT_IRQ;
      end else if (irq_timer && mstatus_mie && mie_mtie) begin
        take_trap = 1'b1;
        cause     = CAUSE_TIMER_IRQ;
      end else
`endif
      if (ex_illegal) begin
        take_trap = 1'b1;
        cause     = CAUSE_ILLEGAL;
      end else if (ex_ecall) begin
        take_trap = 1'b1;
        cause     = CAUSE_ECALL;
      end else if (ex_mret) begin
        take_mret = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer sharing the CSR write port with WB; TRAP_IRQ_EN adds irq_ext/irq_timer.
// Latency: trap writes mepc/mcause/mstatus at T+1..T+3 and redirects at T+4; mret writes at T+1, redirects at T+2.
// Backpressure: a WB CSR write always wins the port; the colliding write state holds one cycle with stall high.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int   XLEN       = 32,
  parameter logic RESET_IDLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_illegal,
  input  logic            ex_ecall,
  input  logic            ex_mret,
`ifdef TRAP_IRQ_EN
  input  logic            irq_ext,
  input  logic            irq_timer,
`endif
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mie,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic            pipe_csr_we,
  input  logic [11:0]     pipe_csr_addr,
  input  logic [XLEN-1:0] pipe_csr_wdata,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            flush,
  output logic            redirect_en,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  trap_state_t     state, state_nxt;
  logic [XLEN-1:0] epc;
  logic [31:0]     cause_q;
  logic            mret_q;
  logic            take_trap, take_mret;
  logic [31:0]     det_cause;
  logic            unused;

  assign unused = ^{csr_mie, csr_mtvec[1:0], RESET_IDLE};

  trap_cause_encoder u_enc (
    .ex_valid    (ex_valid),
    .ex_illegal  (ex_illegal),
    .ex_ecall    (ex_ecall),
    .ex_mret     (ex_mret),
`ifdef TRAP_IRQ_EN
    .irq_ext     (irq_ext),
    .irq_timer   (irq_timer),
    .mstatus_mie (csr_mstatus[MSTATUS_MIE]),
    .mie_meie    (csr_mie[MIE_MEIE]),
    .mie_mtie    (csr_mie[MIE_MTIE]),
`endif
    .take_trap   (take_trap),
    .take_mret   (take_mret),
    .cause       (det_cause)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      epc     <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && (take_trap || take_mret)) begin
        epc     <= ex_pc;
        cause_q <= det_cause;
        mret_q  <= take_mret;
      end
    end
  end

  // Write states only advance in cycles where WB is not using the port.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (take_trap)      state_nxt = ST_W_MEPC;
        else if (take_mret) state_nxt = ST_M_STATUS;
      end
      ST_W_MEPC:    if (!pipe_csr_we) state_nxt = ST_W_MCAUSE;
      ST_W_MCAUSE:  if (!pipe_csr_we) state_nxt = ST_W_MSTATUS;
      ST_W_MSTATUS: if (!pipe_csr_we) state_nxt = ST_JUMP;
      ST_M_STATUS:  if (!pipe_csr_we) state_nxt = ST_JUMP;
      ST_JUMP:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_we      = pipe_csr_we;
    csr_waddr   = pipe_csr_we ? pipe_csr_addr : 12'h0;
    csr_wdata   = pipe_csr_we ? pipe_csr_wdata : '0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    busy        = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (take_trap || take_mret) begin
          stall = 1'b1;
          flush = 1'b1;
        end
      end
      ST_W_MEPC: begin
        stall = 1'b1;
        if (!pipe_csr_we) begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MEPC;
          csr_wdata = epc;
        end
      end
      ST_W_MCAUSE: begin
        stall = 1'b1;
        if (!pipe_csr_we) begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MCAUSE;
          csr_wdata = cause_q;
        end
      end
      ST_W_MSTATUS: begin
        stall = 1'b1;
        if (!pipe_csr_we) begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = trap_mstatus(csr_mstatus);
        end
      end
      ST_M_STATUS: begin
        stall = 1'b1;
        if (!pipe_csr_we) begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = mret_mstatus(csr_mstatus);
        end
      end
      ST_JUMP: begin
        flush       = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = mret_q ? csr_mepc : {csr_mtvec[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: CSR writes and redirects are checked against a timed scoreboard.
// Interrupt scenarios are exercised only when TRAP_IRQ_EN is defined.
module tb_trap_ctrl;

  typedef struct packed {
    logic [31:0] cyc;
    logic        redir;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_illegal, ex_ecall, ex_mret;
  logic [31:0] ex_pc;
`ifdef TRAP_IRQ_EN
  logic        irq_ext, irq_timer;
`endif
  logic [31:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
  logic        pipe_csr_we;
  logic [11:0] pipe_csr_addr;
  logic [31:0] pipe_csr_wdata;
  logic        csr_we, stall, flush, redirect_en, busy;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  t0;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_illegal(ex_illegal),
    .ex_ecall(ex_ecall), .ex_mret(ex_mret),
`ifdef TRAP_IRQ_EN
    .irq_ext(irq_ext), .irq_timer(irq_timer),
`endif
    .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .pipe_csr_we(pipe_csr_we), .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .stall(stall), .flush(flush), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic r, input logic [11:0] a, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.redir = r; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic check_ev(input logic r, input logic [11:0] a, input logic [31:0] d);
    ev_t got, exp;
    got.cyc = cyc; got.redir = r; got.addr = a; got.data = d;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL unexpected_event: observed %h expected none", got);
    end
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      assert (got === exp) else begin
        n_err++;
        $error("FAIL event: observed %h expected %h", got, exp);
      end
    end
  endtask

  // Every CSR write and redirect the DUT produces must match the next scoreboard entry.
  always @(negedge clk) begin
    if (csr_we === 1'b1) check_ev(1'b0, csr_waddr, csr_wdata);
    if (redirect_en === 1'b1) check_ev(1'b1, 12'h0, redirect_pc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [4:0] fl);
`ifdef TRAP_IRQ_EN
    irq_ext   = fl[4];
    irq_timer = fl[3];
`endif
    ex_illegal = fl[2];
    ex_ecall   = fl[1];
    ex_mret    = fl[0];
  endtask

  // flags = {ext, timer, illegal, ecall, mret}; mstatus/mie/mtvec set by the caller.
  task automatic trap_seq(input string tag, input logic [4:0] fl, input logic [31:0] pc,
                          input logic [31:0] exp_cause, input logic [31:0] exp_mst);
    int t;
    step();
    t = cyc;
    ex_valid = 1'b1; ex_pc = pc; set_flags(fl);
    push(t + 1, 1'b0, 12'h341, pc);
    push(t + 2, 1'b0, 12'h342, exp_cause);
    push(t + 3, 1'b0, 12'h300, exp_mst);
    push(t + 4, 1'b1, 12'h0, {csr_mtvec[31:2], 2'b00});
    @(negedge clk);
    chk({tag, "_det_stall"}, {31'h0, stall}, 32'h1);
    chk({tag, "_det_flush"}, {31'h0, flush}, 32'h1);
    step();
    ex_valid = 1'b0; set_flags(5'b0);
    @(negedge clk);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
    step(); step();
    @(negedge clk);
    chk({tag, "_wstat_stall"}, {31'h0, stall}, 32'h1);
    step();
    @(negedge clk);
    chk({tag, "_jump_stall"}, {31'h0, stall}, 32'h0);
    chk({tag, "_jump_flush"}, {31'h0, flush}, 32'h1);
    step();
    @(negedge clk);
    chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
    chk({tag, "_sb_empty"}, sb.size(), 32'h0);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; set_flags(5'b0);
    csr_mstatus = '0; csr_mie = '0; csr_mtvec = '0; csr_mepc = '0;
    pipe_csr_we = 1'b0; pipe_csr_addr = '0; pipe_csr_wdata = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_csr_we", {31'h0, csr_we}, 32'h0);
    chk("rst_waddr", {20'h0, csr_waddr}, 32'h0);
    chk("rst_wdata", csr_wdata, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_redir", {31'h0, redirect_en}, 32'h0);
    chk("rst_redir_pc", redirect_pc, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    step();
    rst = 1'b0;

    // Illegal instruction, basic trap timing.
    csr_mtvec = 32'h205; csr_mstatus = 32'h8;
    trap_seq("illegal", 5'b00100, 32'h100, 32'h2, 32'h1880);

    // mret: mstatus restore then return to mepc.
    csr_mstatus = 32'h1880; csr_mepc = 32'h104;
    step();
    t0 = cyc;
    ex_valid = 1'b1; ex_pc = 32'h210; set_flags(5'b00001);
    push(t0 + 1, 1'b0, 12'h300, 32'h1888);
    push(t0 + 2, 1'b1, 12'h0, 32'h104);
    @(negedge clk);
    chk("mret_det_stall", {31'h0, stall}, 32'h1);
    chk("mret_det_flush", {31'h0, flush}, 32'h1);
    step();
    ex_valid = 1'b0; set_flags(5'b0);
    @(negedge clk);
    chk("mret_w_stall", {31'h0, stall}, 32'h1);
    step();
    @(negedge clk);
    chk("mret_jump_stall", {31'h0, stall}, 32'h0);
    step();
    @(negedge clk);
    chk("mret_idle", {31'h0, busy}, 32'h0);
    chk("mret_sb_empty", sb.size(), 32'h0);

    // Timer pending but globally masked: ecall is taken.
    csr_mie = 32'h80; csr_mstatus = 32'h0;
    trap_seq("ecall", 5'b01010, 32'h180, 32'hB, 32'h1800);

`ifdef TRAP_IRQ_EN
    csr_mstatus = 32'h8;
    trap_seq("timer", 5'b01010, 32'h1C0, 32'h8000_0007, 32'h1880);
    csr_mie = 32'h880;
    trap_seq("ext", 5'b11100, 32'h1E0, 32'h8000_000B, 32'h1880);
    csr_mie = 32'h0;
`endif

    // WB CSR write collides with W_MCAUSE.
    csr_mstatus = 32'h8;
    step();
    t0 = cyc;
    ex_valid = 1'b1; ex_pc = 32'h120; set_flags(5'b00100);
    push(t0 + 1, 1'b0, 12'h341, 32'h120);
    push(t0 + 2, 1'b0, 12'h305, 32'hDEAD);
    push(t0 + 3, 1'b0, 12'h342, 32'h2);
    push(t0 + 4, 1'b0, 12'h300, 32'h1880);
    push(t0 + 5, 1'b1, 12'h0, 32'h204);
    step();
    ex_valid = 1'b0; set_flags(5'b0);
    step();
    pipe_csr_we = 1'b1; pipe_csr_addr = 12'h305; pipe_csr_wdata = 32'hDEAD;
    @(negedge clk);
    chk("coll_stall", {31'h0, stall}, 32'h1);
    step();
    pipe_csr_we = 1'b0; pipe_csr_addr = '0; pipe_csr_wdata = '0;
    step();
    @(negedge clk);
    chk("coll_wstat_stall", {31'h0, stall}, 32'h1);
    step(); step();
    @(negedge clk);
    chk("coll_idle", {31'h0, busy}, 32'h0);
    chk("coll_sb_empty", sb.size(), 32'h0);

    // Reset mid-sequence: the mstatus write and redirect never happen.
    step();
    t0 = cyc;
    ex_valid = 1'b1; ex_pc = 32'h140; set_flags(5'b00100);
    push(t0 + 1, 1'b0, 12'h341, 32'h140);
    push(t0 + 2, 1'b0, 12'h342, 32'h2);
    step();
    ex_valid = 1'b0; set_flags(5'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_csr_we", {31'h0, csr_we}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall}, 32'h0);
    chk("mid_rst_flush", {31'h0, flush}, 32'h0);
    chk("mid_rst_redir", {31'h0, redirect_en}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    repeat (4) step();
    @(negedge clk);
    chk("mid_rst_sb_empty", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
